// File: rtl/terasic_pixel_depth_conv_if.sv
// rtl/terasic_pixel_depth_conv_if.sv - Avalon-ST video sink/source bundle plus status for the depth converter
interface terasic_pixel_depth_conv_if #(
    parameter int IN_BITS  = 10,
    parameter int OUT_BITS = 8,
    parameter int CHANNELS = 3
);
    logic [CHANNELS*IN_BITS-1:0]  sink_data;
    logic                         sink_valid;
    logic                         sink_ready;
    logic                         sink_sop;
    logic                         sink_eop;
    logic [CHANNELS*OUT_BITS-1:0] source_data;
    logic                         source_valid;
    logic                         source_ready;
    logic                         source_sop;
    logic                         source_eop;
    logic [15:0]                  drop_count;
    logic                         sop_error;

    // Converter side.
    modport slave (
        input  sink_data, sink_valid, sink_sop, sink_eop, source_ready,
        output sink_ready, source_data, source_valid, source_sop, source_eop,
        output drop_count, sop_error
    );

    // Upstream producer / downstream consumer side.
    modport master (
        output sink_data, sink_valid, sink_sop, sink_eop, source_ready,
        input  sink_ready, source_data, source_valid, source_sop, source_eop,
        input  drop_count, sop_error
    );
endinterface

// File: rtl/terasic_pixel_depth_conv.sv
// rtl/terasic_pixel_depth_conv.sv - Avalon-ST video pixel depth reducer with packet tracking; optional PIXEL_DEPTH_ROUNDING_EN
module terasic_pixel_depth_conv #(
    parameter int IN_BITS  = 10,
    parameter int OUT_BITS = 8,
    parameter int CHANNELS = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    terasic_pixel_depth_conv_if.slave   bus
);
    localparam int DW_OUT = CHANNELS * OUT_BITS;
    localparam int SHIFT  = IN_BITS - OUT_BITS;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_VIDEO = 2'd1;
    localparam logic [1:0] ST_CTRL  = 2'd2;

    logic [1:0]        r_state;
    logic              r_sink_ready;
    logic [1:0]        r_count;
    logic [DW_OUT-1:0] r_head_data;
    logic              r_head_sop;
    logic              r_head_eop;
    logic [DW_OUT-1:0] r_skid_data;
    logic              r_skid_sop;
    logic              r_skid_eop;
    logic [15:0]       r_drop_count;
    logic              r_sop_error;

    logic              w_accept;
    logic              w_sop_is_ctrl;
    logic              w_fwd;
    logic              w_drop;
    logic              w_ctrl_map;
    logic              w_sop_err_set;
    logic [1:0]        w_state_next;
    logic              w_pop;
    logic [1:0]        w_count_next;
    logic [DW_OUT-1:0] w_ctrl_data;
    logic [DW_OUT-1:0] w_vid_data;
    logic [DW_OUT-1:0] w_mapped;

    assign w_accept      = bus.sink_valid & r_sink_ready;
    assign w_sop_is_ctrl = (bus.sink_data[3:0] == 4'hF);

    // Control packets keep the low channel bits (they carry parameters, not
    // intensities); video keeps the top bits, optionally rounded.
    genvar g;
    for (g = 0; g < CHANNELS; g++) begin : g_ch
        assign w_ctrl_data[g*OUT_BITS +: OUT_BITS] = bus.sink_data[g*IN_BITS +: OUT_BITS];
`ifdef PIXEL_DEPTH_ROUNDING_EN
        logic [OUT_BITS:0] w_sum;
        assign w_sum = {1'b0, bus.sink_data[g*IN_BITS+SHIFT +: OUT_BITS]}
                     + {{OUT_BITS{1'b0}}, bus.sink_data[g*IN_BITS+SHIFT-1]};
        assign w_vid_data[g*OUT_BITS +: OUT_BITS] = w_sum[OUT_BITS] ? {OUT_BITS{1'b1}}
                                                                    : w_sum[OUT_BITS-1:0];
`else
        assign w_vid_data[g*OUT_BITS +: OUT_BITS] = bus.sink_data[g*IN_BITS+SHIFT +: OUT_BITS];
`endif
    end

    assign w_mapped = w_ctrl_map ? w_ctrl_data : w_vid_data;

    // Packet decode: decide forward/drop, mapping kind and next FSM state.
    always_comb begin
        w_fwd         = 1'b0;
        w_drop        = 1'b0;
        w_ctrl_map    = 1'b0;
        w_sop_err_set = 1'b0;
        w_state_next  = r_state;
        if (w_accept) begin
            if (bus.sink_sop) begin
                w_fwd         = 1'b1;
                w_sop_err_set = (r_state != ST_IDLE);
                w_ctrl_map    = w_sop_is_ctrl;
                if (bus.sink_eop)
                    w_state_next = ST_IDLE;
                else
                    w_state_next = w_sop_is_ctrl ? ST_CTRL : ST_VIDEO;
            end else if (r_state == ST_IDLE) begin
                w_drop = 1'b1;
            end else begin
                w_fwd      = 1'b1;
                w_ctrl_map = (r_state == ST_CTRL);
                if (bus.sink_eop)
                    w_state_next = ST_IDLE;
            end
        end
    end

    assign w_pop        = (r_count != 2'd0) & bus.source_ready;
    assign w_count_next = r_count + {1'b0, w_fwd} - {1'b0, w_pop};

    // Packet state machine.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Two-entry skid buffer: head drives the source port, skid catches the
    // beat accepted while the head is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count      <= 2'd0;
            r_sink_ready <= 1'b0;
            r_head_data  <= '0;
            r_head_sop   <= 1'b0;
            r_head_eop   <= 1'b0;
            r_skid_data  <= '0;
            r_skid_sop   <= 1'b0;
            r_skid_eop   <= 1'b0;
        end else begin
            if (w_pop) begin
                if (r_count == 2'd2) begin
                    r_head_data <= r_skid_data;
                    r_head_sop  <= r_skid_sop;
                    r_head_eop  <= r_skid_eop;
                    if (w_fwd) begin
                        r_skid_data <= w_mapped;
                        r_skid_sop  <= bus.sink_sop;
                        r_skid_eop  <= bus.sink_eop;
                    end
                end else if (w_fwd) begin
                    r_head_data <= w_mapped;
                    r_head_sop  <= bus.sink_sop;
                    r_head_eop  <= bus.sink_eop;
                end
            end else if (w_fwd) begin
                if (r_count == 2'd0) begin
                    r_head_data <= w_mapped;
                    r_head_sop  <= bus.sink_sop;
                    r_head_eop  <= bus.sink_eop;
                end else begin
                    r_skid_data <= w_mapped;
                    r_skid_sop  <= bus.sink_sop;
                    r_skid_eop  <= bus.sink_eop;
                end
            end
            r_count      <= w_count_next;
            r_sink_ready <= (w_count_next < 2'd2);
        end
    end

    // Saturating count of beats discarded outside a packet.
    always_ff @(posedge clk) begin
        if (reset)
            r_drop_count <= 16'd0;
        else if (w_drop && (r_drop_count != 16'hFFFF))
            r_drop_count <= r_drop_count + 16'd1;
    end

    // Sticky flag for a sop arriving inside an open packet.
    always_ff @(posedge clk) begin
        if (reset)
            r_sop_error <= 1'b0;
        else if (w_sop_err_set)
            r_sop_error <= 1'b1;
    end

    assign bus.sink_ready   = r_sink_ready;
    assign bus.source_valid = (r_count != 2'd0);
    assign bus.source_data  = r_head_data;
    assign bus.source_sop   = r_head_sop;
    assign bus.source_eop   = r_head_eop;
    assign bus.drop_count   = r_drop_count;
    assign bus.sop_error    = r_sop_error;
endmodule

// File: tb/tb_terasic_pixel_depth_conv.sv
// tb/tb_terasic_pixel_depth_conv.sv - scoreboard bench for terasic_pixel_depth_conv
module tb_terasic_pixel_depth_conv;
    localparam int IN_BITS  = 10;
    localparam int OUT_BITS = 8;
    localparam int CHANNELS = 3;
    localparam int DW_IN    = CHANNELS * IN_BITS;
    localparam int DW_OUT   = CHANNELS * OUT_BITS;
    localparam int SHIFT    = IN_BITS - OUT_BITS;

    typedef logic [DW_OUT+1:0] exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    terasic_pixel_depth_conv_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .CHANNELS(CHANNELS)) bus ();

    terasic_pixel_depth_conv #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .CHANNELS(CHANNELS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    int   cur_fwd  = 0;
    bit   chk_en   = 1'b0;
    int   rdy_mode = 0;

    bit   m_in_pkt;
    bit   m_ctrl;
    bit   exp_sop_err;
    int   exp_drop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW_OUT-1:0] map_beat(input logic [DW_IN-1:0] d, input bit ctrl);
        logic [DW_OUT-1:0] r;
        logic [DW_IN-1:0]  t;
        int v;
        int o;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            t = d >> (c * IN_BITS);
            v = int'(t) % (1 << IN_BITS);
            if (ctrl)
                o = v % (1 << OUT_BITS);
            else begin
`ifdef PIXEL_DEPTH_ROUNDING_EN
                o = (v + (1 << (SHIFT - 1))) / (1 << SHIFT);
                if (o > (1 << OUT_BITS) - 1) o = (1 << OUT_BITS) - 1;
`else
                o = v / (1 << SHIFT);
`endif
            end
            r[c*OUT_BITS +: OUT_BITS] = o[OUT_BITS-1:0];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_in_pkt    = 1'b0;
        m_ctrl      = 1'b0;
        exp_sop_err = 1'b0;
        exp_drop    = 0;
        sb.delete();
        cur_fwd     = 0;
    endtask

    task automatic model_accept(input logic [DW_IN-1:0] d, input bit s, input bit e);
        if (s) begin
            if (m_in_pkt) exp_sop_err = 1'b1;
            m_ctrl   = (d[3:0] == 4'hF);
            m_in_pkt = !e;
            sb.push_back({map_beat(d, m_ctrl), s, e});
            cur_fwd = 1;
        end else if (!m_in_pkt) begin
            if (exp_drop < 16'hFFFF) exp_drop++;
        end else begin
            sb.push_back({map_beat(d, m_ctrl), s, e});
            cur_fwd = 1;
            if (e) m_in_pkt = 1'b0;
        end
    endtask

    // Called in the posedge+1 phase; returns in the same phase one beat later.
    task automatic send_beat(input logic [DW_IN-1:0] d, input bit s, input bit e);
        int budget;
        budget = 0;
        bus.sink_data  = d;
        bus.sink_sop   = s;
        bus.sink_eop   = e;
        bus.sink_valid = 1'b1;
        while (!bus.sink_ready && budget < 500) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!bus.sink_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: sink_ready stayed %0b expected 1", bus.sink_ready);
            bus.sink_valid = 1'b0;
            return;
        end
        model_accept(d, s, e);
        @(posedge clk); #1;
        cur_fwd        = 0;
        bus.sink_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.sink_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 3000) begin
            @(posedge clk); #1;
            budget++;
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d beats left expected 0", sb.size());
        end
    endtask

    function automatic logic [DW_IN-1:0] rand_beat(input bit force_video);
        logic [DW_IN-1:0] d;
        d = DW_IN'($urandom);
        if (force_video && d[3:0] == 4'hF) d[0] = 1'b0;
        return d;
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.source_ready = 1'b1;
            1:       bus.source_ready = 1'($urandom_range(0, 1));
            default: bus.source_ready = 1'b0;
        endcase
    end

    // Monitor: occupancy-derived handshake checks, hold stability, and
    // in-order comparison against the scoreboard queue.
    exp_t prev_beat;
    bit   prev_hold = 1'b0;
    always @(negedge clk) begin
        exp_t cur;
        exp_t want;
        int   occ;
        cur = {bus.source_data, bus.source_sop, bus.source_eop};
        if (!chk_en) begin
            prev_hold = 1'b0;
        end else begin
            occ = sb.size() - cur_fwd;
            check("sink_ready_vs_fill", bus.sink_ready, (occ < 2));
            check("source_valid_vs_fill", bus.source_valid, (occ > 0));
            if (prev_hold) begin
                check("hold_valid", bus.source_valid, 1);
                check("hold_beat", cur, prev_beat);
            end
            if (bus.source_valid && bus.source_ready && sb.size() > 0) begin
                want = sb.pop_front();
                check("beat", cur, want);
            end
            prev_hold = bus.source_valid && !bus.source_ready;
            prev_beat = cur;
        end
    end

    task automatic apply_reset();
        chk_en         = 1'b0;
        bus.sink_valid = 1'b0;
        reset          = 1'b1;
        @(posedge clk); #1;
        check("rst_source_valid", bus.source_valid, 0);
        check("rst_sink_ready", bus.sink_ready, 0);
        check("rst_drop_count", bus.drop_count, 0);
        check("rst_sop_error", bus.sop_error, 0);
        @(posedge clk); #1;
        model_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", bus.sink_ready, 1);
        chk_en = 1'b1;
    endtask

    initial begin
        bus.sink_data    = '0;
        bus.sink_valid   = 1'b0;
        bus.sink_sop     = 1'b0;
        bus.sink_eop     = 1'b0;
        bus.source_ready = 1'b1;
        reset            = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check("init_source_data", bus.source_data, 0);
        check("init_source_sop", bus.source_sop, 0);
        check("init_source_eop", bus.source_eop, 0);
        apply_reset();

        // Stray beats before any sop are dropped, then a video packet.
        for (int i = 0; i < 5; i++) send_beat(rand_beat(1'b0), 1'b0, 1'b0);
        idle(3);
        check("drop_count_5", bus.drop_count, 5);
        send_beat(30'h0000_0A3, 1'b1, 1'b0);
        send_beat({10'h004, 10'h3FE, 10'h2FF}, 1'b0, 1'b1);
        drain();
        idle(2);
        check("drop_count_still_5", bus.drop_count, 5);

        // Control packet, then a beat that must fall into IDLE and be dropped.
        send_beat({10'h000, 10'h000, 10'h00F}, 1'b1, 1'b0);
        send_beat({10'h3FF, 10'h1C3, 10'h2A5}, 1'b0, 1'b1);
        send_beat(rand_beat(1'b0), 1'b0, 1'b0);
        drain();
        idle(2);
        check("drop_after_ctrl", bus.drop_count, 6);

        // One-beat packet leaves the FSM idle.
        send_beat(rand_beat(1'b1), 1'b1, 1'b1);
        send_beat(rand_beat(1'b0), 1'b0, 1'b1);
        drain();
        idle(2);
        check("drop_after_single", bus.drop_count, 7);
        check("no_sop_error_yet", bus.sop_error, 0);

        // sop inside an open video packet.
        send_beat(rand_beat(1'b1), 1'b1, 1'b0);
        send_beat(rand_beat(1'b0), 1'b0, 1'b0);
        send_beat(rand_beat(1'b0), 1'b0, 1'b0);
        send_beat(rand_beat(1'b1), 1'b1, 1'b0);
        send_beat(rand_beat(1'b0), 1'b0, 1'b1);
        drain();
        idle(2);
        check("sop_error_set", bus.sop_error, exp_sop_err);
        send_beat(rand_beat(1'b1), 1'b1, 1'b1);
        drain();
        idle(2);
        check("sop_error_sticky", bus.sop_error, 1);

        // Reset with two beats held in the buffer.
        rdy_mode = 2;
        idle(2);
        send_beat(rand_beat(1'b1), 1'b1, 1'b0);
        send_beat(rand_beat(1'b0), 1'b0, 1'b0);
        check("buffer_full_ready", bus.sink_ready, 0);
        chk_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk); #1;
        check("midpkt_rst_valid", bus.source_valid, 0);
        check("midpkt_rst_ready", bus.sink_ready, 0);
        check("midpkt_rst_drop", bus.drop_count, 0);
        check("midpkt_rst_sop_err", bus.sop_error, 0);
        model_reset();
        rdy_mode = 0;
        reset    = 1'b0;
        @(posedge clk); #1;
        check("midpkt_ready_back", bus.sink_ready, 1);
        chk_en = 1'b1;
        send_beat(rand_beat(1'b0), 1'b0, 1'b1);
        send_beat(rand_beat(1'b1), 1'b1, 1'b1);
        drain();
        idle(2);
        check("post_rst_drop", bus.drop_count, 1);

        // 100-beat video packet against a 50% random consumer.
        rdy_mode = 1;
        for (int i = 0; i < 100; i++) begin
            send_beat(rand_beat(1'b1), (i == 0), (i == 99));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();

        // Mixed random traffic: stray beats, nested sops, control packets.
        for (int i = 0; i < 300; i++) begin
            send_beat(rand_beat(1'b0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 5) == 0) idle(1);
        end
        drain();
        idle(2);
        check("rand_drop_count", bus.drop_count, exp_drop);
        check("rand_sop_error", bus.sop_error, exp_sop_err);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/terasic_pixel_depth_conv.md
TERASIC_PIXEL_DEPTH_CONV -- requirements
Module: terasic_pixel_depth_conv

Interface
REQ-001 SHALL have parameter IN_BITS, default 10: bits per colour channel on sink; legal range OUT_BITS+1..16.
REQ-002 SHALL have parameter OUT_BITS, default 8: bits per colour channel on source; legal range 4..15.
REQ-003 SHALL have parameter CHANNELS, default 3: colour channels per beat, channel 0 in the LSBs; legal range 1..4.
REQ-004 SHALL have port clk, input, 1: single clock; one clock, all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have sink_data input CHANNELS*IN_BITS, sink_valid input 1, sink_ready output 1, sink_sop input 1, sink_eop input 1: Avalon-ST video sink, ready latency 0.
REQ-007 SHALL have source_data output CHANNELS*OUT_BITS, source_valid output 1, source_ready input 1, source_sop output 1, source_eop output 1: Avalon-ST video source, ready latency 0.
REQ-008 SHALL have port drop_count, output, 16: saturating count of discarded sink beats.
REQ-009 SHALL have port sop_error, output, 1: sticky flag, sop received inside an open packet.

Function
REQ-010 SHALL accept a sink beat when sink_valid & sink_ready; source beat transfers when source_valid & source_ready.
REQ-011 SHALL implement packet FSM IDLE, VIDEO, CTRL; reset state IDLE.
REQ-012 SHALL classify an accepted sop beat as control when channel 0 bits [3:0] == 4'hF, else video; next state CTRL or VIDEO.
REQ-013 SHALL return to IDLE after an accepted eop beat; a sop+eop beat is a complete one-beat packet and leaves FSM in IDLE.
REQ-014 SHALL, on accepted sop while in VIDEO or CTRL, set sop_error, forward the beat, and re-classify the new packet.
REQ-015 SHALL, in IDLE, discard accepted beats without sop (not forwarded), incrementing drop_count, saturating at 16'hFFFF.
REQ-016 SHALL map control-packet beats (sop beat classified control, or any beat in CTRL) per channel to bits [OUT_BITS-1:0].
REQ-017 SHALL map video-packet beats per channel to bits [IN_BITS-1:IN_BITS-OUT_BITS] (truncation) unless REQ-027 applies.
REQ-018 SHALL pass sop and eop unchanged with their beat.
REQ-019 SHALL register output through a 2-entry skid buffer: latency exactly 1 cycle from sink acceptance to source_valid when buffer empty.
REQ-020 SHALL drive sink_ready from a register: high when skid buffer holds fewer than 2 entries after the current cycle's transfers.
REQ-021 SHALL sustain one beat per clock with source_ready held high.
REQ-022 SHALL hold source_data/sop/eop stable while source_valid & ~source_ready.
REQ-023 SHALL, with buffer full and simultaneous source transfer, accept no sink beat that cycle; readiness returns next cycle.

Reset
REQ-024 SHALL on reset set source_valid=0, source_data=0, source_sop=0, source_eop=0, sink_ready=0, drop_count=0, sop_error=0, FSM=IDLE, buffer empty.
REQ-025 SHALL raise sink_ready the first cycle after reset deasserts.
REQ-026 SHALL on reset mid-packet discard buffered beats; no partial packet emitted afterwards (next forwarded beat must carry sop).

Configuration
REQ-027 SHALL, with macro PIXEL_DEPTH_ROUNDING_EN defined, round video channels: out = top OUT_BITS + bit[IN_BITS-OUT_BITS-1], saturated at 2^OUT_BITS-1; control beats unaffected.
REQ-028 SHALL, without PIXEL_DEPTH_ROUNDING_EN, truncate per REQ-017 and contain no rounding adder.

Verification (IN_BITS=10, OUT_BITS=8, CHANNELS=3)
REQ-029 SHALL test video beat sop=1, ch0=10'h2FF, ch1=10'h3FE, ch2=10'h004 -> one cycle later source_data {8'h01,8'hFF,8'hBF} (no macro); {8'h01,8'hFF,8'hC0} with PIXEL_DEPTH_ROUNDING_EN.
REQ-030 SHALL test control packet sop ch0=10'h00F, then beat ch0=10'h2A5 ch1=10'h1C3 ch2=10'h3FF eop -> second output {8'hFF,8'hC3,8'hA5}, FSM back to IDLE.
REQ-031 SHALL test 5 non-sop beats after reset -> no source_valid, drop_count=5; then sop beat forwarded, drop_count unchanged.
REQ-032 SHALL test 100-beat video packet with source_ready random 50% -> all 100 beats output in order, no loss/duplication, sink_ready never high with buffer full.
REQ-033 SHALL test sop at beat 3 of open video packet -> sop_error=1, beat forwarded with sop=1, remains 1 until reset.
REQ-034 SHALL test reset asserted with 2 beats buffered -> next cycle source_valid=0, sink_ready=0, drop_count=0.
